transmitter: RTL and testbench

- Self-contained FSK test transmitter for the NCO subsystem.
- An internal PRBS-7 bit source selects one of two NCO tuning words per bit period.
- A phase-continuous 16-bit phase accumulator addresses a 64-entry sine table, which drives a registered 4-bit unsigned DAC code.
- Free-running after reset; no data or control inputs.

---
 rtl/tx_pkg.sv | 35 +++
 rtl/transmitter_nco.sv | 36 +++
 rtl/transmitter.sv | 48 ++++
 tb/tb_transmitter.sv | 99 +++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared constants and sine table for the FSK test transmitter.
// The NCO and the bit-timing logic in the top both import this package.
package tx_pkg;

  localparam int ACC_W      = 16;
  localparam int LUT_AW     = 6;
  localparam int DAC_W      = 4;
  localparam int BIT_PERIOD = 128;
  localparam int CNT_W      = $clog2(BIT_PERIOD);

  localparam logic [ACC_W-1:0] STEP0     = 16'd1024;
  localparam logic [ACC_W-1:0] STEP1     = 16'd2048;
  localparam logic [6:0]       PRBS_SEED = 7'h7F;
  localparam logic [DAC_W-1:0] DAC_MID   = 4'd8;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_PERIOD - 1);

  // One full sine period, entry p = floor(7.5 + 7.5*sin(2*pi*p/64) + 0.5).
  // The table is not a clean quarter-wave mirror (entry 32 is 8, not 7),
  // so the full table is stored.
  localparam logic [DAC_W-1:0] SINE_LUT [64] = '{
    4'd8,  4'd8,  4'd9,  4'd10, 4'd10, 4'd11, 4'd12, 4'd12,
    4'd13, 4'd13, 4'd14, 4'd14, 4'd14, 4'd15, 4'd15, 4'd15,
    4'd15, 4'd15, 4'd15, 4'd15, 4'd14, 4'd14, 4'd14, 4'd13,
    4'd13, 4'd12, 4'd12, 4'd11, 4'd10, 4'd10, 4'd9,  4'd8,
    4'd8,  4'd7,  4'd6,  4'd5,  4'd5,  4'd4,  4'd3,  4'd3,
    4'd2,  4'd2,  4'd1,  4'd1,  4'd1,  4'd0,  4'd0,  4'd0,
    4'd0,  4'd0,  4'd0,  4'd0,  4'd1,  4'd1,  4'd1,  4'd2,
    4'd2,  4'd3,  4'd3,  4'd4,  4'd5,  4'd5,  4'd6,  4'd7
  };

  function automatic logic [DAC_W-1:0] sine_lut(input logic [LUT_AW-1:0] addr);
    return SINE_LUT[addr];
  endfunction

endpackage

// File: rtl/transmitter_nco.sv
// Phase-continuous NCO: free-running phase accumulator, sine lookup and a
// single output register that drives the DAC code.
module nco
  import tx_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [ACC_W-1:0] step,
  output logic [DAC_W-1:0] dac
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [DAC_W-1:0] dac_q, dac_d;

  // The table is addressed with the pre-update phase, so dac lags acc by
  // exactly one register stage. The accumulator wraps naturally.
  always_comb begin
    acc_d = acc_q + step;
    dac_d = sine_lut(acc_q[ACC_W-1 -: LUT_AW]);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      dac_q <= DAC_MID;
    end else begin
      acc_q <= acc_d;
      dac_q <= dac_d;
    end
  end

  assign dac = dac_q;

endmodule

// File: rtl/transmitter.sv
// FSK test transmitter: PRBS-7 data bits pick one of two NCO tuning words,
// one bit every BIT_PERIOD clocks.
module transmitter
  import tx_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  output logic [DAC_W-1:0] dac
);

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [6:0]       lfsr_q, lfsr_d;
  logic [ACC_W-1:0] step;
  logic             data_bit;

  assign data_bit = lfsr_q[6];
  assign step     = data_bit ? STEP1 : STEP0;

  // NOTE: every signal assigned here gets a default first, so no path
  // through the block leaves a value held (which would infer a latch).
  always_comb begin
    bit_cnt_d = bit_cnt_q + 1'b1;
    lfsr_d    = lfsr_q;
    if (bit_cnt_q == BIT_LAST) begin
      bit_cnt_d = '0;
      // x^7 + x^6 + 1, maximal length (127 bits)
      lfsr_d    = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt_q <= '0;
      lfsr_q    <= PRBS_SEED;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      lfsr_q    <= lfsr_d;
    end
  end

  nco u_nco (
    .clk   (clk),
    .reset (reset),
    .step  (step),
    .dac   (dac)
  );

endmodule

// File: tb/tb_transmitter.sv
// Directed bench for the FSK transmitter: reset behaviour, bit-1 waveform,
// the first 1->0 frequency switch, async mid-run reset and a full PRBS period.
module tb_transmitter;

  logic       clk;
  logic       reset;
  logic [3:0] dac;

  int n_cmp = 0;
  int n_bad = 0;

  int lut_ref [64];
  int prbs    [127];

  transmitter dut (
    .clk   (clk),
    .reset (reset),
    .dac   (dac)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Run n_edges clocks from a fresh reset release and compare every dac sample.
  // Phase is tracked in table-address units: bit 1 advances 2, bit 0 advances 1.
  task automatic run_seq(input string tag, input int n_edges);
    int addr;
    int b;
    addr = 0;
    for (int n = 1; n <= n_edges; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", tag, n), int'(dac), lut_ref[addr]);
      case (n)
        9:   check($sformatf("%s peak", tag), int'(dac), 15);
        25:  check($sformatf("%s trough", tag), int'(dac), 0);
        896: check($sformatf("%s pre-switch", tag), int'(dac), 6);
        897: check($sformatf("%s switch addr0", tag), int'(dac), 8);
        899: check($sformatf("%s switch addr2", tag), int'(dac), 9);
        913: check($sformatf("%s switch addr16", tag), int'(dac), 15);
        default: ;
      endcase
      b    = prbs[((n - 1) / 128) % 127];
      addr = (addr + (b != 0 ? 2 : 1)) % 64;
    end
  endtask

  task automatic hold_reset(input string tag, input int n_edges);
    reset = 1'b0;
    #1;
    check($sformatf("%s async", tag), int'(dac), 8);
    for (int i = 0; i < n_edges; i++) begin
      @(negedge clk);
      check($sformatf("%s hold[%0d]", tag, i), int'(dac), 8);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    real x;
    for (int p = 0; p < 64; p++) begin
      x = 7.5 + 7.5 * $sin(2.0 * 3.14159265358979 * real'(p) / 64.0) + 0.5 + 1.0e-9;
      lut_ref[p] = $rtoi($floor(x));
    end
    // Output sequence of x^7+x^6+1 from seed 7'h7F: s[n+7] = s[n] ^ s[n+1].
    for (int n = 0; n < 7; n++) prbs[n] = 1;
    for (int n = 7; n < 127; n++) prbs[n] = prbs[n-7] ^ prbs[n-6];

    reset = 1'b0;
    @(negedge clk);
    hold_reset("por", 5);

    // After 500 clocks dac is LUT[38]=3, so an immediate 8 proves async reset.
    run_seq("first", 500);
    #2;
    hold_reset("mid", 3);

    run_seq("restart", 1100);
    @(negedge clk);
    hold_reset("pre_long", 2);

    run_seq("long", 127 * 128 + 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
